counter_fsm: RTL and testbench
==============================

COUNTER_FSM -- requirements
Module: counter_fsm

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits (1..16).
REQ-002 The block SHALL have parameter DIV_COUNT, default 1500000: clk cycles per count step (>=1).
REQ-003 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port go  input  1  start request, active-high level, sampled each clk.
REQ-006 The block SHALL have port stop  input  1  abort request, active-high.
REQ-007 The block SHALL have port pause  input  1  hold count while high.
REQ-008 The block SHALL have port mode  input  2  bit0 direction (0 up, 1 down), bit1 auto-reload (1) vs one-shot (0).
REQ-009 The block SHALL have port limit  input  WIDTH  terminal value (up) / start value (down).
REQ-010 The block SHALL have port count  output  WIDTH  current count.
REQ-011 The block SHALL have port busy  output  1  high when state != IDLE.
REQ-012 The block SHALL have port done  output  1  Mealy terminal pulse, exactly one clk cycle.

Function
REQ-013 The state machine SHALL have states IDLE, COUNTING and PAUSED.
REQ-014 In IDLE, go=1 SHALL latch mode and limit, load count with start value (0 up, limit down), clear prescaler, and enter COUNTING next cycle.
REQ-015 The latched mode/limit SHALL be used until return to IDLE; mode/limit changes mid-run SHALL have no effect.
REQ-016 The prescaler SHALL count 0..DIV_COUNT-1 only in COUNTING and assert tick for one cycle when it equals DIV_COUNT-1, then wrap to 0.
REQ-017 The first step SHALL therefore occur exactly DIV_COUNT cycles after entering COUNTING; DIV_COUNT=1 steps every cycle.
REQ-018 On tick with count != end value (limit up, 0 down), count SHALL increment (up) or decrement (down) by 1.
REQ-019 done SHALL be combinational: done = (state==COUNTING) & tick & (count==end value) & ~stop & ~pause.
REQ-020 In the done cycle, one-shot SHALL go to IDLE and reload start value; auto-reload SHALL reload start value and stay in COUNTING.
REQ-021 count SHALL never exceed latched limit nor wrap modulo 2^WIDTH.
REQ-022 limit=0 SHALL assert done on the first tick in either direction.
REQ-023 pause=1 in COUNTING SHALL enter PAUSED next cycle; PAUSED SHALL freeze count and prescaler; pause=0 SHALL return to COUNTING, resuming the prescaler from its frozen value.
REQ-024 stop=1 in any state SHALL enter IDLE next cycle with count reloaded to start value and no done pulse.
REQ-025 Priority SHALL be rst > stop > pause > tick; go SHALL be ignored outside IDLE.
REQ-026 go and stop high together in IDLE SHALL leave the block in IDLE.

Reset
REQ-027 rst=1 at a clk edge SHALL force state IDLE, prescaler 0, count 0, latched mode 0, latched limit 0.
REQ-028 During and after reset, busy=0 and done=0; reset mid-run SHALL abort with no done pulse.

Structure
REQ-029 State encoding (2-bit) and mode bit positions SHALL live in shared package counter_fsm_pkg.
REQ-030 The prescaler SHALL be a sub-module tick_gen (parameter DIV_COUNT; inputs clk, rst, en, clr; output tick).
REQ-031 The prescaler width SHALL be $clog2(DIV_COUNT+1); no derived clocks SHALL be generated.

Verification (WIDTH=4, DIV_COUNT=3)
REQ-032 Up one-shot, limit=5, go 1 cycle -> count 0..5 stepping every 3 cycles, done single cycle while count=5, then IDLE, count=0, busy=0.
REQ-033 Down auto-reload, limit=2 -> count 2,1,0, done at 0, reload 2, busy stays 1, second done after 9 further cycles.
REQ-034 Up one-shot limit=15 -> done at count 15 and return to 0, never 16 or wrap before done.
REQ-035 pause high 7 cycles at count=3 -> count holds 3, PAUSED busy=1, resumes with remaining prescaler phase preserved.
REQ-036 stop at count=4, and separately rst at count=4 -> IDLE next cycle, count=0, no done; go+stop together in IDLE -> stays IDLE.
REQ-037 limit=0 up and down -> done exactly 3 cycles after entering COUNTING.

Source files
------------

// File: rtl/counter_fsm_pkg.sv
// ============================================================================
// Module   : counter_fsm_pkg
// Brief    : Shared state encoding and mode-bit positions for counter_fsm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_PAUSED   = 2'd2
  } state_e;

  localparam int MODE_DIR_BIT    = 0;  // 0 = up, 1 = down
  localparam int MODE_RELOAD_BIT = 1;  // 0 = one-shot, 1 = auto-reload

endpackage : counter_fsm_pkg

`default_nettype wire

// File: rtl/counter_fsm_tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Brief    : Enable-gated prescaler; one-cycle tick every DIV_COUNT enabled cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int DIV_COUNT = 1500000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW    = $clog2(DIV_COUNT + 1);
  localparam logic [CW-1:0] LAST  = CW'(DIV_COUNT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Holding en low freezes the phase, so a pause resumes mid-period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en & ~clr & (cnt_q == LAST);

endmodule : tick_gen

`default_nettype wire

// File: rtl/counter_fsm.sv
// ============================================================================
// Module   : counter_fsm
// Brief    : Prescaled up/down counter with one-shot/auto-reload, pause and stop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_fsm
  import counter_fsm_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV_COUNT = 1500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             stop,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       mode_q,  mode_d;
  logic [WIDTH-1:0] limit_q, limit_d;

  logic             tick;
  logic             presc_en;
  logic             presc_clr;
  logic             done_raw;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] end_val;

  // Prescaler only advances on cycles where a step could actually be taken.
  assign presc_en  = (state_q == ST_COUNTING) & ~stop & ~pause;
  assign presc_clr = (state_q == ST_IDLE) | stop;

  tick_gen #(
    .DIV_COUNT (DIV_COUNT)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  assign start_val = mode_q[MODE_DIR_BIT] ? limit_q : '0;
  assign end_val   = mode_q[MODE_DIR_BIT] ? '0      : limit_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mode_d   = mode_q;
    limit_d  = limit_q;
    done_raw = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (stop) begin
          count_d = start_val;
        end else if (go) begin
          mode_d  = mode;
          limit_d = limit;
          count_d = mode[MODE_DIR_BIT] ? limit : '0;
          state_d = ST_COUNTING;
        end
      end
      ST_COUNTING: begin
        if (stop) begin
          count_d = start_val;
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (tick) begin
          if (count_q == end_val) begin
            done_raw = 1'b1;
            count_d  = start_val;
            if (!mode_q[MODE_RELOAD_BIT]) begin
              state_d = ST_IDLE;
            end
          end else if (mode_q[MODE_DIR_BIT]) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      ST_PAUSED: begin
        if (stop) begin
          count_d = start_val;
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_COUNTING;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      mode_q  <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      limit_q <= limit_d;
    end
  end

  // Outputs are masked while rst is asserted so an aborted run never flags done.
  assign count = count_q;
  assign busy  = (state_q != ST_IDLE) & ~rst;
  assign done  = done_raw & ~rst;

endmodule : counter_fsm

`default_nettype wire

// File: tb/tb_counter_fsm.sv
// ============================================================================
// Module   : tb_counter_fsm
// Brief    : Directed self-checking bench for counter_fsm (WIDTH=4, DIV_COUNT=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_fsm;

  localparam int WIDTH     = 4;
  localparam int DIV_COUNT = 3;

  logic             clk;
  logic             rst;
  logic             go;
  logic             stop;
  logic             pause;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  int checks;
  int errors;
  int dseen;

  counter_fsm #(
    .WIDTH     (WIDTH),
    .DIV_COUNT (DIV_COUNT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .stop  (stop),
    .pause (pause),
    .mode  (mode),
    .limit (limit),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dseen++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    dseen  = 0;
    rst = 1'b1; go = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'b00; limit = '0;

    // Reset
    step_n(2);
    check("rst_count", 32'(count), 0);
    check("rst_busy",  32'(busy),  0);
    check("rst_done",  32'(done),  0);
    rst = 1'b0;
    step_n(1);
    check("idle_busy", 32'(busy), 0);

    // Up one-shot, limit 5; mid-run mode/limit changes must be ignored
    mode = 2'b00; limit = 4'd5; go = 1'b1;
    step_n(1);
    go = 1'b0; mode = 2'b11; limit = 4'd9;
    check("up_start_busy",  32'(busy),  1);
    check("up_start_count", 32'(count), 0);
    dseen = 0;
    step_n(3);
    check("up_first_step", 32'(count), 1);
    step_n(12);
    check("up_at5", 32'(count), 5);
    step_n(2);
    check("up_done",       32'(done),  1);
    check("up_done_count", 32'(count), 5);
    check("up_done_once",  32'(dseen), 1);
    step_n(1);
    check("up_end_busy",  32'(busy),  0);
    check("up_end_count", 32'(count), 0);
    check("up_end_done",  32'(done),  0);

    // Down auto-reload, limit 2
    mode = 2'b11; limit = 4'd2; go = 1'b1;
    step_n(1);
    go = 1'b0;
    check("dn_start_count", 32'(count), 2);
    step_n(3);
    check("dn_step1", 32'(count), 1);
    step_n(3);
    check("dn_step0", 32'(count), 0);
    step_n(2);
    check("dn_done1", 32'(done), 1);
    step_n(1);
    check("dn_reload_count", 32'(count), 2);
    check("dn_reload_busy",  32'(busy),  1);
    dseen = 0;
    step_n(8);
    check("dn_done2",      32'(done),  1);
    check("dn_done2_once", 32'(dseen), 1);
    stop = 1'b1;
    step_n(1);
    stop = 1'b0;
    check("dn_stop_busy",  32'(busy),  0);
    check("dn_stop_count", 32'(count), 2);

    // Up one-shot, limit 15: reaches 15 without wrapping
    mode = 2'b00; limit = 4'd15; go = 1'b1;
    step_n(1);
    go = 1'b0;
    dseen = 0;
    step_n(45);
    check("max_at15",    32'(count), 15);
    check("max_no_done", 32'(dseen), 0);
    step_n(2);
    check("max_done", 32'(done), 1);
    step_n(1);
    check("max_end_count", 32'(count), 0);
    check("max_end_busy",  32'(busy),  0);

    // Pause for 7 cycles at count 3, prescaler phase preserved; then stop at 4
    mode = 2'b00; limit = 4'd5; go = 1'b1;
    step_n(1);
    go = 1'b0;
    dseen = 0;
    step_n(10);
    check("ps_at3", 32'(count), 3);
    pause = 1'b1;
    step_n(1);
    check("ps_busy", 32'(busy), 1);
    step_n(6);
    check("ps_hold",      32'(count), 3);
    check("ps_hold_busy", 32'(busy),  1);
    pause = 1'b0;
    step_n(2);
    check("ps_resume_hold", 32'(count), 3);
    step_n(1);
    check("ps_resume_step", 32'(count), 4);
    stop = 1'b1;
    step_n(1);
    stop = 1'b0;
    check("stop_busy",    32'(busy),  0);
    check("stop_count",   32'(count), 0);
    check("stop_no_done", 32'(dseen), 0);

    // Reset mid-run at count 4
    go = 1'b1;
    step_n(1);
    go = 1'b0;
    dseen = 0;
    step_n(12);
    check("rr_at4", 32'(count), 4);
    rst = 1'b1;
    #1;
    check("rr_busy_in_rst", 32'(busy), 0);
    step_n(1);
    rst = 1'b0;
    #1;
    check("rr_count",   32'(count), 0);
    check("rr_busy",    32'(busy),  0);
    check("rr_no_done", 32'(dseen), 0);

    // go and stop together in IDLE
    go = 1'b1; stop = 1'b1;
    step_n(1);
    go = 1'b0; stop = 1'b0;
    check("gostop_busy", 32'(busy), 0);
    step_n(1);
    check("gostop_busy2", 32'(busy), 0);

    // limit 0, up then down: done in third COUNTING cycle
    mode = 2'b00; limit = 4'd0; go = 1'b1;
    step_n(1);
    go = 1'b0;
    step_n(1);
    check("l0up_early", 32'(done), 0);
    step_n(1);
    check("l0up_done", 32'(done), 1);
    step_n(1);
    check("l0up_idle", 32'(busy), 0);
    mode = 2'b01; go = 1'b1;
    step_n(1);
    go = 1'b0;
    step_n(1);
    check("l0dn_early", 32'(done), 0);
    step_n(1);
    check("l0dn_done",  32'(done),  1);
    check("l0dn_count", 32'(count), 0);
    step_n(1);
    check("l0dn_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_counter_fsm

`default_nettype wire
